// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory / camera arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_RD    = 2'd1,
        CAM_BURST = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_AW          = 14;
    localparam int unsigned DEF_DW          = 32;
    localparam int unsigned DEF_FIFO_DEPTH  = 8;
    localparam int unsigned DEF_HIGH_WATER  = 6;
    localparam int unsigned DEF_BURST_MAX   = 4;
    localparam int unsigned DEF_CAM_BASE    = 32'h2000;
    localparam int unsigned DEF_FRAME_WORDS = 4800;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cam_fifo.sv
// Synchronous FIFO buffering camera words ahead of the RAM.
// A push while full is accepted when a pop frees a slot in the same cycle.
module cam_fifo
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned CW   = cnt_width(DEPTH),
    localparam int unsigned IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + IW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + IW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_cam_arbiter.sv
// Arbitrates the single-port data RAM between CPU loads/stores and the
// camera pixel stream. Optional ARB_STATS_EN adds stall / camera-write
// counters; without it those ports read as zero.
module dmem_cam_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned   AW          = DEF_AW,
    parameter int unsigned   DW          = DEF_DW,
    parameter int unsigned   FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned   HIGH_WATER  = DEF_HIGH_WATER,
    parameter int unsigned   BURST_MAX   = DEF_BURST_MAX,
    parameter logic [AW-1:0] CAM_BASE    = AW'(DEF_CAM_BASE),
    parameter int unsigned   FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          stallM,
    input  logic          cam_valid,
    input  logic [DW-1:0] cam_data,
    output logic          cam_ready,
    input  logic          cam_frame_start,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          frame_done,
    output logic          overflow,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   cam_words
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned BW = cnt_width(BURST_MAX);

    arb_state_t    state;
    logic [BW-1:0] burst_cnt;
    logic [AW-1:0] cam_ptr;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;

    logic          push;
    logic          high_water;
    logic          last_word;
    logic          go_burst;
    logic          burst_exit;
    logic          cpu_wr;
    logic          cpu_rd;
    logic          cam_wr;
    logic [AW-1:0] cpu_word;
    logic          unused_addr_bits;

    assign cpu_word         = cpu_addr[AW+1:2];
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0]};
    assign cam_ready        = !fifo_full;
    assign push             = cam_valid && !fifo_full;
    assign high_water       = (fifo_count >= CW'(HIGH_WATER));
    assign last_word        = (cam_ptr == AW'(FRAME_WORDS - 1));

    cam_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (push),
        .pop   (cam_wr),
        .din   (cam_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Decide who owns the RAM this cycle; everything is quiet during reset.
    always_comb begin
        go_burst   = 1'b0;
        burst_exit = 1'b0;
        cpu_wr     = 1'b0;
        cpu_rd     = 1'b0;
        cam_wr     = 1'b0;
        stallM     = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (high_water) begin
                        go_burst = 1'b1;
                        stallM   = cpu_req;
                    end else if (cpu_req && cpu_we) begin
                        cpu_wr = 1'b1;
                    end else if (cpu_req) begin
                        cpu_rd = 1'b1;
                        stallM = 1'b1;
                    end else if (!fifo_empty) begin
                        cam_wr = 1'b1;
                    end
                end
                CAM_BURST: begin
                    stallM     = cpu_req;
                    cam_wr     = !fifo_empty;
                    burst_exit = fifo_empty
                              || ((fifo_count == CW'(1)) && !push)
                              || (burst_cnt == BW'(BURST_MAX - 1));
                end
                default: begin
                end
            endcase
        end
    end

    // RAM port and load-data steering.
    always_comb begin
        ram_en    = cpu_wr || cpu_rd || cam_wr;
        ram_we    = cpu_wr || cam_wr;
        ram_addr  = cam_wr ? (CAM_BASE + cam_ptr) : cpu_word;
        ram_wdata = cam_wr ? fifo_dout : cpu_wdata;
        cpu_rdata = (state == CPU_RD) ? ram_rdata : '0;
    end

    // Arbiter state and burst length tracking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go_burst) begin
                        state <= CAM_BURST;
                    end else if (cpu_rd) begin
                        state <= CPU_RD;
                    end
                end
                CPU_RD: begin
                    state <= IDLE;
                end
                CAM_BURST: begin
                    if (burst_exit) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Frame-buffer pointer, end-of-frame pulse and sticky overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cam_ptr    <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= cam_wr && last_word;
            if (cam_frame_start) begin
                cam_ptr <= '0;
            end else if (cam_wr) begin
                cam_ptr <= last_word ? '0 : cam_ptr + AW'(1);
            end
            if (cam_valid && !cam_ready) begin
                overflow <= 1'b1;
            end else if (cam_frame_start) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef ARB_STATS_EN
    // Saturating activity counters, restarted every frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            cam_words    <= '0;
        end else if (cam_frame_start) begin
            stall_cycles <= '0;
            cam_words    <= '0;
        end else begin
            if (stallM && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (cam_wr && (cam_words != '1)) begin
                cam_words <= cam_words + 32'd1;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign cam_words    = '0;
`endif

endmodule

// File: tb/tb_dmem_cam_arbiter.sv
// Self-checking bench for dmem_cam_arbiter: a queue-based reference model
// predicts every output each cycle; directed phases add literal checks.
module tb_dmem_cam_arbiter;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned HW    = 6;
    localparam int unsigned BMAX  = 4;
    localparam int unsigned FW    = 4800;
    localparam int unsigned CAMB  = 32'h2000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req, cpu_we, cam_valid, cam_frame_start;
    logic [31:0] cpu_addr, cpu_wdata, cam_data, ram_rdata;
    logic [31:0] cpu_rdata, ram_wdata, stall_cycles, cam_words;
    logic        stallM, cam_ready, ram_en, ram_we, frame_done, overflow;
    logic [13:0] ram_addr;

    always #5 clock = ~clock;

    dmem_cam_arbiter u_dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .stallM          (stallM),
        .cam_valid       (cam_valid),
        .cam_data        (cam_data),
        .cam_ready       (cam_ready),
        .cam_frame_start (cam_frame_start),
        .ram_en          (ram_en),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_wdata       (ram_wdata),
        .ram_rdata       (ram_rdata),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .stall_cycles    (stall_cycles),
        .cam_words       (cam_words)
    );

    // Environment RAM: one-cycle read latency.
    bit [31:0] ram [0:16383];
    always @(posedge clock) begin
        if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= ram[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] q[$];
    bit [31:0]   ref_mem [0:16383];
    int          ptr;
    int          burst_left;
    bit          rd_pend;
    int          rd_addr;
    bit          ovf;
    bit          fd;
    longint      sc;
    longint      cw;

    // Snapshot of DUT outputs from the last checked cycle.
    bit          s_stall, s_en, s_we, s_ready, s_ovf, s_fd;
    logic [31:0] s_addr, s_wd, s_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        ptr        = 0;
        burst_left = 0;
        rd_pend    = 1'b0;
        rd_addr    = 0;
        ovf        = 1'b0;
        fd         = 1'b0;
        sc         = 0;
        cw         = 0;
    endfunction

    // One clock: drive, predict, compare at negedge, advance model.
    task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit cv, input logic [31:0] cd,
                         input bit fs);
        int          cnt;
        bit          cam_w, cpu_w, cpu_r, start_b, push, fd_n;
        bit          e_stall, e_en, e_we, e_ready;
        logic [31:0] e_addr, e_wd, e_rd, w;
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        cam_valid = cv; cam_data = cd; cam_frame_start = fs;
        @(negedge clock);
        if (!reset) model_reset();
        cnt = q.size();
        cam_w = 0; cpu_w = 0; cpu_r = 0; start_b = 0;
        e_stall = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_rd = 0;
        e_ready = (cnt < DEPTH);
        if (reset) begin
            if (rd_pend) e_rd = ref_mem[rd_addr];
            else if (burst_left > 0) begin e_stall = req; cam_w = (cnt > 0); end
            else if (cnt >= HW) begin e_stall = req; start_b = 1; end
            else if (req && we) cpu_w = 1;
            else if (req) begin cpu_r = 1; e_stall = 1; end
            else if (cnt > 0) cam_w = 1;
        end
        if (cam_w) begin e_en = 1; e_we = 1; e_addr = (CAMB + ptr) & 32'h3FFF; e_wd = q[0]; end
        if (cpu_w) begin e_en = 1; e_we = 1; e_addr = (addr >> 2) & 32'h3FFF; e_wd = wd; end
        if (cpu_r) begin e_en = 1; e_addr = (addr >> 2) & 32'h3FFF; end

        s_stall = stallM; s_en = ram_en; s_we = ram_we; s_ready = cam_ready;
        s_ovf = overflow; s_fd = frame_done; s_addr = 32'(ram_addr); s_wd = ram_wdata;
        s_rd = cpu_rdata;
        chk("stallM", 32'(s_stall), 32'(e_stall));
        chk("ram_en", 32'(s_en), 32'(e_en));
        chk("ram_we", 32'(s_we), 32'(e_we));
        chk("cam_ready", 32'(s_ready), 32'(e_ready));
        chk("overflow", 32'(s_ovf), 32'(ovf));
        chk("frame_done", 32'(s_fd), 32'(fd));
        chk("cpu_rdata", s_rd, e_rd);
        if (e_en) chk("ram_addr", s_addr, e_addr);
        if (e_we) chk("ram_wdata", s_wd, e_wd);
`ifdef ARB_STATS_EN
        chk("stall_cycles", stall_cycles, 32'(sc));
        chk("cam_words", cam_words, 32'(cw));
`else
        chk("stall_cycles", stall_cycles, 32'd0);
        chk("cam_words", cam_words, 32'd0);
`endif

        if (reset) begin
            push = cv && (cnt < DEPTH);
            fd_n = 0;
            if (cam_w) begin
                w = q.pop_front();
                ref_mem[e_addr[13:0]] = w;
                fd_n = (ptr == FW - 1);
                ptr = fd_n ? 0 : ptr + 1;
            end
            if (cpu_w) ref_mem[e_addr[13:0]] = wd;
            if (push) q.push_back(cd);
            if (burst_left > 0) begin
                if (!cam_w || q.size() == 0) burst_left = 0;
                else burst_left--;
            end
            if (start_b) burst_left = BMAX;
            rd_pend = cpu_r;
            if (cpu_r) rd_addr = int'(e_addr);
            if (fs) ptr = 0;
            if (fs) ovf = 0;
            if (cv && cnt >= DEPTH) ovf = 1;
            fd = fd_n;
            if (fs) begin sc = 0; cw = 0; end
            else begin
                if (e_stall && sc < 64'hFFFF_FFFF) sc++;
                if (cam_w && cw < 64'hFFFF_FFFF) cw++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        int fd_pulses, widx;
        bit ready_low_seen, seen;
        int cvp, rqp;
        ram_rdata = '0;
        model_reset();

        // Reset state
        idle(3);
        chk("rst_stallM", 32'(s_stall), 32'd0);
        chk("rst_ram_en", 32'(s_en), 32'd0);
        chk("rst_cam_ready", 32'(s_ready), 32'd1);
        chk("rst_overflow", 32'(s_ovf), 32'd0);
        chk("rst_frame_done", 32'(s_fd), 32'd0);
        reset = 1'b1;
        idle(2);

        // Single-cycle store, then one-stall load of the same word
        cycle(1, 1, 32'h0000_0010, 32'h1234_5678, 0, 0, 0);
        chk("st_en", 32'(s_en), 32'd1);
        chk("st_we", 32'(s_we), 32'd1);
        chk("st_addr", s_addr, 32'd4);
        chk("st_wdata", s_wd, 32'h1234_5678);
        chk("st_stall", 32'(s_stall), 32'd0);
        cycle(1, 0, 32'h0000_0010, 0, 0, 0, 0);
        chk("ld_stall", 32'(s_stall), 32'd1);
        chk("ld_we", 32'(s_we), 32'd0);
        cycle(1, 0, 32'h0000_0010, 0, 0, 0, 0);
        chk("ld_stall2", 32'(s_stall), 32'd0);
        chk("ld_rdata", s_rd, 32'h1234_5678);
        idle(1);

        // High-water burst while loads are pending
        for (int k = 0; k <= 12; k++) begin
            cycle(1, 0, 32'h0000_0010, 0, k < 6, 32'hC0DE_0000 + 32'(k), 0);
            if (k == 6) begin
                chk("hw_stall", 32'(s_stall), 32'd1);
                chk("hw_noaccess", 32'(s_en), 32'd0);
            end
            if (k >= 7 && k <= 10) begin
                chk("burst_we", 32'(s_we), 32'd1);
                chk("burst_addr", s_addr, 32'h2000 + 32'(k - 7));
                chk("burst_data", s_wd, 32'hC0DE_0000 + 32'(k - 7));
                chk("burst_stall", 32'(s_stall), 32'd1);
            end
            if (k == 11) chk("post_burst_rd", s_addr, 32'd4);
            if (k == 12) chk("post_burst_rdata", s_rd, 32'h1234_5678);
        end
        idle(5);

        // Full frame of camera words: wrap and single frame_done pulse
        cycle(0, 0, 0, 0, 0, 0, 1);
        fd_pulses = 0; widx = 0;
        for (int n = 0; n < int'(FW) + 6; n++) begin
            cycle(0, 0, 0, 0, n <= int'(FW), 32'hF000_0000 + 32'(n), 0);
            if (s_fd) fd_pulses++;
            if (s_en && s_we) begin
                if (widx == int'(FW) - 1) chk("frame_last_addr", s_addr, 32'h32BF);
                if (widx == int'(FW)) chk("frame_wrap_addr", s_addr, 32'h2000);
                widx++;
            end
        end
        chk("frame_done_pulses", 32'(fd_pulses), 32'd1);
        chk("frame_words", 32'(widx), 32'(FW + 1));

        // Overflow under CPU store pressure, cleared by frame start
        ready_low_seen = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(1, 1, 32'h0000_0040, 32'hAAAA_0000 + 32'(k), 1, 32'hBB00_0000 + 32'(k), 0);
            if (!s_ready) ready_low_seen = 1;
        end
        chk("ready_low_seen", 32'(ready_low_seen), 32'd1);
        chk("ovf_set", 32'(s_ovf), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(s_ovf), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            if (k == 0) chk("ovf_cleared", 32'(s_ovf), 32'd0);
            if (s_en && s_we) begin
                seen = 1;
                chk("fs_ptr_reset", s_addr, 32'h2000);
            end
        end
        chk("fs_write_seen", 32'(seen), 32'd1);
        idle(20);

        // Asynchronous reset in the load-data cycle with 3 words queued
        for (int k = 0; k < 3; k++) cycle(1, 0, 32'h0000_0010, 0, 1, 32'h5500_0000 + 32'(k), 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cam_valid = 0; cam_frame_start = 0;
        #2;
        chk("cpu_rd_live", cpu_rdata, 32'h1234_5678);
        reset = 1'b0;
        #1;
        chk("arst_stallM", 32'(stallM), 32'd0);
        chk("arst_ram_en", 32'(ram_en), 32'd0);
        chk("arst_cam_ready", 32'(cam_ready), 32'd1);
        chk("arst_rdata", cpu_rdata, 32'd0);
        @(posedge clock);
        #1;
        cycle(1, 0, 32'h10, 0, 0, 0, 0);
        chk("arst_hold_stall", 32'(s_stall), 32'd0);
        reset = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("arst_fifo_empty", 32'(s_en), 32'd0);

        // Randomized traffic
        cvp = 50; rqp = 50;
        for (int i = 0; i < 3000; i++) begin
            bit r, w, v, f;
            logic [31:0] a;
            if (i % 500 == 0) begin
                cvp = int'($urandom_range(10, 95));
                rqp = int'($urandom_range(10, 95));
            end
            if (i == 1500) begin
                reset = 1'b0;
                idle(2);
                reset = 1'b1;
            end
            r = (int'($urandom_range(0, 99)) < rqp);
            w = 1'($urandom_range(0, 1));
            v = (int'($urandom_range(0, 99)) < cvp);
            f = ($urandom_range(0, 199) == 0);
            a = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
            cycle(r, w, a, $urandom, v, $urandom, f);
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
